// File: rtl/rgb_pwm_gen.sv
// Dual RGB LED PWM generator with period-boundary (shadowed) duty and select loading.
module rgb_pwm_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PWM_MAX = 254
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] rgb_disp,
    output logic [2:0]  led0_rgb,
    output logic [2:0]  led1_rgb,
    output logic        period_start
);

    localparam int unsigned PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]    CNT_LAST   = 8'(PWM_MAX);

    logic [PW-1:0] presc;
    logic [7:0]    cnt;
    logic [31:0]   shadow;
    logic          tick_c;
    logic          wrap_c;
    logic [2:0]    pwm_c;

    // Tick and end-of-period detection; a divide ratio of 1 ticks every cycle.
    always_comb begin
        tick_c = (CLK_DIV == 1) ? 1'b1 : (presc == PRESC_LAST);
        wrap_c = tick_c && (cnt == CNT_LAST);
        pwm_c  = {(cnt < shadow[23:16]), (cnt < shadow[15:8]), (cnt < shadow[7:0])};
    end

    // Prescaler: cleared while disabled so re-enable starts a clean period.
    always_ff @(posedge sys_clk) begin
        if (rst || !enable) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // PWM counter advances once per tick and wraps after the last value.
    always_ff @(posedge sys_clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
        end
    end

    // Shadow tracks the display word while idle, otherwise only at period wrap.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (!enable || wrap_c) begin
            shadow <= rgb_disp;
        end
    end

    // Registered compare and LED select decode, plus the period boundary pulse.
    always_ff @(posedge sys_clk) begin
        if (rst || !enable) begin
            led0_rgb     <= '0;
            led1_rgb     <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap_c;
            case (shadow[31:24])
                8'h01: begin
                    led0_rgb <= pwm_c;
                    led1_rgb <= '0;
                end
                8'h02: begin
                    led0_rgb <= '0;
                    led1_rgb <= pwm_c;
                end
                default: begin
                    led0_rgb <= '0;
                    led1_rgb <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen: directed scenarios plus randomized traffic
// compared against a cycle-position reference model, at prescale ratios 1 and 4.
module tb_rgb_pwm_gen;

    logic        sys_clk;
    logic        rst;
    logic        enable;
    logic [31:0] rgb_disp;
    logic [2:0]  l0_1, l1_1, l0_4, l1_4;
    logic        ps_1, ps_4;
    logic [6:0]  act [2];

    int checks = 0;
    int errors = 0;

    rgb_pwm_gen #(.CLK_DIV(1), .PWM_MAX(254)) u_div1 (
        .sys_clk(sys_clk), .rst(rst), .enable(enable), .rgb_disp(rgb_disp),
        .led0_rgb(l0_1), .led1_rgb(l1_1), .period_start(ps_1));

    rgb_pwm_gen #(.CLK_DIV(4), .PWM_MAX(254)) u_div4 (
        .sys_clk(sys_clk), .rst(rst), .enable(enable), .rgb_disp(rgb_disp),
        .led0_rgb(l0_4), .led1_rgb(l1_4), .period_start(ps_4));

    assign act[0] = {l0_1, l1_1, ps_1};
    assign act[1] = {l0_4, l1_4, ps_4};

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Reference model: position in the period measured in clock cycles.
    int unsigned m_pos [2];
    logic [31:0] m_sh  [2];
    logic [6:0]  m_exp [2];

    function automatic logic [5:0] model_leds(input logic [31:0] sh, input int unsigned tk);
        logic [2:0] p;
        p = {tk < 32'(sh[23:16]), tk < 32'(sh[15:8]), tk < 32'(sh[7:0])};
        if (sh[31:24] == 8'h01) return {p, 3'b000};
        if (sh[31:24] == 8'h02) return {3'b000, p};
        return 6'b0;
    endfunction

    always @(posedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            int unsigned div;
            int unsigned plen;
            div  = (k == 0) ? 1 : 4;
            plen = div * 255;
            if (rst) begin
                m_pos[k] = 0;
                m_sh[k]  = 32'h0;
                m_exp[k] = 7'h0;
            end else if (!enable) begin
                m_pos[k] = 0;
                m_sh[k]  = rgb_disp;
                m_exp[k] = 7'h0;
            end else begin
                m_exp[k] = {model_leds(m_sh[k], m_pos[k] / div), m_pos[k] == plen - 1};
                if (m_pos[k] == plen - 1) begin
                    m_pos[k] = 0;
                    m_sh[k]  = rgb_disp;
                end else begin
                    m_pos[k] = m_pos[k] + 1;
                end
            end
        end
    end

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b1;
        rgb_disp = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({act[0], act[1]} !== 14'h0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h/%h need 0/0", i, act[0], act[1]);
            end
            rgb_disp = $urandom;
        end
        rst = 1'b0;
    endtask

    task automatic test_div1_duty();
        int n;
        int cr, cg, cb, c1, cps;
        bit ps_last;
        rgb_disp = 32'h0180_00FF;
        enable   = 1'b1;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!ps_1 && n < 600);
        checks++;
        if (!ps_1) begin errors++; $display("FAIL div1_wait_ps: got 0 need 1"); end
        cr = 0; cg = 0; cb = 0; c1 = 0; cps = 0; ps_last = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge sys_clk);
            cr += l0_1[2]; cg += l0_1[1]; cb += l0_1[0];
            c1 += (l1_1 != 3'b0);
            cps += ps_1;
            if (i == 255) ps_last = ps_1;
        end
        checks++;
        if (cr != 128) begin errors++; $display("FAIL div1_red: got %0d need 128", cr); end
        checks++;
        if (cg != 0) begin errors++; $display("FAIL div1_green: got %0d need 0", cg); end
        checks++;
        if (cb != 255) begin errors++; $display("FAIL div1_blue: got %0d need 255", cb); end
        checks++;
        if (c1 != 0) begin errors++; $display("FAIL div1_led1: got %0d need 0", c1); end
        checks++;
        if (cps != 1 || !ps_last) begin
            errors++;
            $display("FAIL div1_ps_spacing: got count %0d last %0d need 1 1", cps, ps_last);
        end
    endtask

    task automatic test_select();
        int n;
        rgb_disp = 32'h02FF_FFFF;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!ps_1 && n < 600);
        repeat (3) @(negedge sys_clk);
        checks++;
        if (l1_1 !== 3'b111 || l0_1 !== 3'b000) begin
            errors++;
            $display("FAIL sel2: got led0=%b led1=%b need 000 111", l0_1, l1_1);
        end
        rgb_disp = 32'h05FF_FFFF;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!ps_1 && n < 600);
        repeat (3) @(negedge sys_clk);
        checks++;
        if (l1_1 !== 3'b000 || l0_1 !== 3'b000) begin
            errors++;
            $display("FAIL sel5: got led0=%b led1=%b need 000 000", l0_1, l1_1);
        end
    endtask

    task automatic test_mid_update();
        int n, c1, c2;
        rgb_disp = 32'h0110_0000;
        // Let one boundary load the new word, then align to the following one.
        for (int w = 0; w < 2; w++) begin
            n = 0;
            do begin @(negedge sys_clk); n++; end while (!ps_1 && n < 600);
        end
        checks++;
        if (!ps_1) begin errors++; $display("FAIL mid_wait_ps: got 0 need 1"); end
        c1 = 0; c2 = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge sys_clk);
            c1 += l0_1[2];
            if (i == 50) rgb_disp = 32'h01F0_0000;
        end
        for (int i = 1; i <= 255; i++) begin
            @(negedge sys_clk);
            c2 += l0_1[2];
        end
        checks++;
        if (c1 != 16) begin errors++; $display("FAIL mid_old_period: got %0d need 16", c1); end
        checks++;
        if (c2 != 240) begin errors++; $display("FAIL mid_new_period: got %0d need 240", c2); end
    endtask

    task automatic test_enable_drop();
        int n, cr, cps;
        bit ps_last;
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!ps_1 && n < 600);
        repeat (100) @(negedge sys_clk);
        enable   = 1'b0;
        rgb_disp = 32'h0130_0000;
        @(negedge sys_clk);
        checks++;
        if ({act[0], act[1]} !== 14'h0) begin
            errors++;
            $display("FAIL en_drop: got %h/%h need 0/0", act[0], act[1]);
        end
        repeat (4) @(negedge sys_clk);
        enable = 1'b1;
        cr = 0; cps = 0; ps_last = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge sys_clk);
            cr  += l0_1[2];
            cps += ps_1;
            if (i == 255) ps_last = ps_1;
        end
        checks++;
        if (cr != 48) begin errors++; $display("FAIL reen_red: got %0d need 48", cr); end
        checks++;
        if (cps != 1 || !ps_last) begin
            errors++;
            $display("FAIL reen_ps: got count %0d last %0d need 1 1", cps, ps_last);
        end
    endtask

    task automatic test_div4();
        int n, cr, cps;
        bit ps_last;
        rgb_disp = 32'h0140_0000;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            do begin @(negedge sys_clk); n++; end while (!ps_4 && n < 2100);
        end
        checks++;
        if (!ps_4) begin errors++; $display("FAIL div4_wait_ps: got 0 need 1"); end
        cr = 0; cps = 0; ps_last = 0;
        for (int i = 1; i <= 1020; i++) begin
            @(negedge sys_clk);
            cr  += l0_4[2];
            cps += ps_4;
            if (i == 1020) ps_last = ps_4;
        end
        checks++;
        if (cr != 256) begin errors++; $display("FAIL div4_red: got %0d need 256", cr); end
        checks++;
        if (cps != 1 || !ps_last) begin
            errors++;
            $display("FAIL div4_ps_spacing: got count %0d last %0d need 1 1", cps, ps_last);
        end
        repeat (37) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        checks++;
        if ({act[0], act[1]} !== 14'h0) begin
            errors++;
            $display("FAIL div4_mid_reset: got %h/%h need 0/0", act[0], act[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] sel;
        for (int i = 0; i < 5000; i++) begin
            @(negedge sys_clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== m_exp[k]) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL rand div%0d cyc%0d: got %b need %b",
                                 (k == 0) ? 1 : 4, i, act[k], m_exp[k]);
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       sel = 8'h01;
                    1:       sel = 8'h02;
                    2:       sel = 8'h01;
                    default: sel = 8'($urandom);
                endcase
                rgb_disp = {sel, 8'($urandom), 8'($urandom), 8'($urandom)};
                if ($urandom_range(0, 3) == 0) rgb_disp[23:16] = 8'hFF;
                if ($urandom_range(0, 3) == 0) rgb_disp[7:0]   = 8'h00;
            end
        end
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        rgb_disp = 32'h0;
        test_reset();
        test_div1_duty();
        test_select();
        test_mid_update();
        test_enable_drop();
        test_div4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
